// File: rtl/dmux_stream_if.sv
// Stream bundle for the 1-to-N demultiplexer: one producer side, CHANNELS consumer
// sides flattened into packed vectors, plus the out-of-range drop counter.
interface dmux_stream_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [15:0]               drop_count;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop_count
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop_count
  );
endinterface

// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer with broadcast and a saturating counter
// of transfers discarded for an out-of-range select.
module dmux_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input logic          clk,
  input logic          reset,
  dmux_stream_if.slave bus
);
  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  logic [CHANNELS-1:0]       vld_p0;
  logic [CHANNELS*WIDTH-1:0] data_p0;
  logic [15:0]               drop_p0;

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] load;
  logic                in_range;
  logic                rdy;
  logic                accept;
  logic                drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A channel can take new data if it is empty or its consumer drains it this edge.
  always_comb begin
    free     = ~vld_p0 | bus.out_ready;
    in_range = ({1'b0, bus.in_sel} < CH_LIM);
    hit      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      hit[k] = bus.in_bcast || (in_range && (bus.in_sel == SEL_W'(k)));
    end
    if (reset) begin
      rdy = 1'b0;
    end else if (bus.in_bcast) begin
      rdy = &free;
    end else if (in_range) begin
      rdy = |(hit & free);
    end else begin
      rdy = 1'b1;
    end
    accept = bus.in_valid && rdy;
    load   = accept ? hit : '0;
    drop   = accept && !bus.in_bcast && !in_range;
  end

  // Stage p0: per-channel holding registers; a load beats a simultaneous drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= '0;
      data_p0 <= '0;
      drop_p0 <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load[k]) begin
          vld_p0[k]                   <= 1'b1;
          data_p0[k*WIDTH +: WIDTH]   <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          vld_p0[k]                   <= 1'b0;
        end
      end
      if (drop) begin
        drop_p0 <= sat_inc(drop_p0);
      end
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = vld_p0;
  assign bus.out_data   = data_p0;
  assign bus.drop_count = drop_p0;
endmodule

// File: doc/dmux_stream.md
# dmux_stream

Parametrised, registered 1-to-N stream demultiplexer. Generalises the combinational 1-bit, 2-way DMux to WIDTH-bit data, CHANNELS outputs, valid/ready flow control, a broadcast mode and out-of-range select accounting. Each output channel owns a one-entry holding register, so a stalled consumer blocks only traffic addressed to its own channel. Sits between a single producer and multiple consumers in the datapath.

## Interface
- WIDTH, 16, data width per transfer (≥1)
- CHANNELS, 4, number of output channels (≥2, need not be a power of two)
- SEL_W, derived localparam = max(1, clog2(CHANNELS)), select width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  WIDTH  input payload
- in_sel  in  SEL_W  target channel index
- in_bcast  in  1  broadcast: deliver in_data to every channel; in_sel ignored
- in_valid  in  1  producer has a transfer
- in_ready  out  1  block accepts a transfer this cycle
- out_data  out  CHANNELS*WIDTH  channel k payload at [k*WIDTH +: WIDTH]
- out_valid  out  CHANNELS  bit k: channel k holds a transfer
- out_ready  in  CHANNELS  bit k: consumer k takes the transfer
- drop_count  out  16  number of transfers discarded for out-of-range in_sel

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out on channel k: out_valid[k] & out_ready[k] at a rising edge.
- Channel k is "free" when !out_valid[k] or out_ready[k] (draining this cycle).
- in_ready (combinational from in_sel, in_bcast, out_valid, out_ready; never from in_valid):
  - reset high: 0.
  - in_bcast=1: AND of free over all channels.
  - in_bcast=0, in_sel < CHANNELS: free(in_sel).
  - in_bcast=0, in_sel ≥ CHANNELS: 1 (accept and discard).
- On an accepted transfer:
  - unicast in range: channel in_sel loads in_data, sets out_valid.
  - broadcast: every channel loads in_data and sets out_valid.
  - out of range: no channel changes; drop_count increments, saturating at 16'hFFFF.
- Channel register update per edge: load wins over drain (valid stays 1, data replaced); drain without load clears out_valid[k]; otherwise hold.
- out_data[k] changes only on a load into channel k; holds its last value after draining. Content is meaningful only while out_valid[k]=1.
- Consumers may hold out_ready high or low arbitrarily; out_valid[k] and out_data[k] are stable while out_valid[k]=1 and out_ready[k]=0.
- No state machine beyond per-channel valid flags and the drop counter.

## Timing
- Reset (sync, reset high at an edge): out_valid = 0, out_data = 0, drop_count = 0. Any in_valid during reset is ignored. Reset asserted mid-stream discards all held transfers; in-flight handshakes that edge are lost.
- Latency: accepted at edge T → out_valid[k]=1 and out_data[k] valid after T (visible in cycle T+1).
- Throughput: one transfer per cycle, sustained to a single channel if its out_ready stays high (drain and load in the same edge).
- Simultaneous events: loads into channel a and drains on other channels in the same edge are independent. Broadcast with some channels draining and others empty succeeds in one edge.
- drop_count increments on the edge of the discarded transfer; it holds at 16'hFFFF once reached.

## Test plan
- WIDTH=16, CHANNELS=3. Reset, then in_sel=1, in_data=16'hA5A5, in_valid=1 for one cycle, out_ready=3'b000 → out_valid=3'b010, out_data[1]=16'hA5A5 next cycle; second transfer to sel=1 sees in_ready=0; sel=2 (16'h0001) accepted → out_valid=3'b110.
- Channel 0 back-to-back, out_ready[0]=1: data 1,2,3,4 on consecutive cycles → in_ready stays 1, out_data[0] shows 1,2,3,4 one cycle later each, no bubbles.
- in_sel=3 (out of range), in_valid=1 for 5 cycles → in_ready=1, out_valid unchanged, drop_count=5; force counter near limit (65540 drops) → drop_count=16'hFFFF.
- Broadcast 16'h1234 with channel 2 full and out_ready=3'b000 → in_ready=0; set out_ready[2]=1 → accepted that edge, all out_data=16'h1234, out_valid=3'b111.
- Fill all channels, assert reset one cycle → out_valid=0, out_data=0, drop_count=0, in_ready=0 during reset.
- Stall: channel 1 full, out_ready[1]=0 for 10 cycles → out_data[1] and out_valid[1] constant throughout.
